// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with single-step and prescaled free-running advance,
// all-zero lock-up recovery, and sequence-period measurement after every seed load.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   load         load seed this cycle (wins over any advance)
//   seed         seed value
//   step         single advance request, level-sampled every cycle
//   run          free-running enable, one advance every DIV cycles
//   q            current LFSR state
//   zero         q == 0, registered with q
//   recovered    one-cycle pulse after an all-zero recovery
//   period       last measured period (WIDTH+1 bits)
//   period_valid period holds a completed measurement
//   period_ovf   measurement saturated without returning to the seed
module lfsr_gen #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'h1D),
  parameter int unsigned      DIV          = 4,
  parameter bit               AUTO_RECOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  input  logic             run,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             recovered,
  output logic [WIDTH:0]   period,
  output logic             period_valid,
  output logic             period_ovf
);

  localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PresMax  = PW'(DIV - 1);
  localparam logic [PW-1:0]  PresOne  = PW'(1);
  localparam logic [WIDTH:0] CntMax   = '1;
  localparam logic [WIDTH:0] CntOne   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] Recover = AUTO_RECOVER ? WIDTH'(1) : '0;

  typedef enum logic [1:0] {StIdle, StMeas, StDone} state_e;

  state_e           st_q, st_d;
  logic [PW-1:0]    pres_q, pres_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] q_d, q_adv;
  logic [WIDTH:0]   cnt_q, cnt_d, cnt_next;
  logic [WIDTH:0]   period_d;
  logic             valid_d, ovf_d, rec_d, zero_d;
  logic             tick, adv, fb, lockup;

  // Prescaler: tick in the cycle the count sits at DIV-1, so the first run advance lands on the
  // DIV-th edge at which run is sampled high.
  always_comb begin
    tick   = run & (pres_q == PresMax);
    adv    = step | tick;
    pres_d = (!run || load || tick) ? '0 : pres_q + PresOne;
  end

  always_comb begin
    fb     = ^(q & TAPS);
    lockup = (q == '0);
    q_adv  = lockup ? Recover : {fb, q[WIDTH-1:1]};
  end

  always_comb begin
    q_d      = q;
    seed_d   = seed_q;
    rec_d    = 1'b0;
    st_d     = st_q;
    cnt_d    = cnt_q;
    cnt_next = cnt_q + CntOne;
    period_d = period;
    valid_d  = period_valid;
    ovf_d    = period_ovf;

    if (load) begin
      q_d     = seed;
      seed_d  = seed;
      st_d    = StMeas;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (adv) begin
      q_d   = q_adv;
      rec_d = lockup & AUTO_RECOVER;
      if (st_q == StMeas) begin
        if (q_adv == seed_q) begin
          period_d = cnt_next;
          valid_d  = 1'b1;
          st_d     = StDone;
        end else if (cnt_next == CntMax) begin
          // Never returned to the seed (e.g. zero seed with recovery): saturate and stop.
          period_d = cnt_next;
          ovf_d    = 1'b1;
          st_d     = StDone;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end

    zero_d = (q_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= StIdle;
      pres_q       <= '0;
      seed_q       <= '0;
      cnt_q        <= '0;
      q            <= '0;
      zero         <= 1'b1;
      recovered    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ovf   <= 1'b0;
    end else begin
      st_q         <= st_d;
      pres_q       <= pres_d;
      seed_q       <= seed_d;
      cnt_q        <= cnt_d;
      q            <= q_d;
      zero         <= zero_d;
      recovered    <= rec_d;
      period       <= period_d;
      period_valid <= valid_d;
      period_ovf   <= ovf_d;
    end
  end

endmodule
